// File: rtl/apb_timer.sv
`default_nettype none
// ============================================================================
// Module      : apb_timer
// Description : APB3 slave timer. 32-bit down-counter driven by a 16-bit
//               prescaler, with reload, one-shot/periodic modes and a
//               registered level interrupt. Fixed two-cycle APB transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_timer #(
    parameter int          ADDR_W   = 30,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RST_LOAD = 32'hFFFF_FFFF
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [3:0]        pwstrb,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              timer_irq
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_LOAD     = 3'd2;
    localparam logic [2:0] OFF_COUNT    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    // Register state
    logic              en;
    logic              auto_rl;
    logic              ie;
    logic [15:0]       prescale;
    logic [15:0]       presc_cnt;
    logic [DATA_W-1:0] load;
    logic [DATA_W-1:0] count;
    logic              pend;
    logic [2:0]        sel_off;

    // Only paddr[4:2] selects a register; the rest is intentionally ignored
    logic unused_addr;
    assign unused_addr = ^{paddr[ADDR_W-1:5], paddr[1:0]};

    // Byte-lane merge of write data into an existing 32-bit value
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                               input logic [DATA_W-1:0] new_v,
                                               input logic [3:0]        strb);
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    logic setup;
    logic access_wr;
    logic wr_ctrl, wr_prescale, wr_load, wr_count, wr_status;
    logic tick;
    logic expire;
    logic [2:0] cur_off;
    logic [DATA_W-1:0] rd_data;

    assign setup     = psel & ~penable;
    assign access_wr = psel & penable & pready & pwrite;
    assign cur_off   = paddr[4:2];

    // A strobe-less write is a complete no-op, so every write enable needs a lane
    assign wr_ctrl     = access_wr & (sel_off == OFF_CTRL)     & pwstrb[0];
    assign wr_prescale = access_wr & (sel_off == OFF_PRESCALE) & (|pwstrb[1:0]);
    assign wr_load     = access_wr & (sel_off == OFF_LOAD)     & (|pwstrb);
    assign wr_count    = access_wr & (sel_off == OFF_COUNT)    & (|pwstrb);
    assign wr_status   = access_wr & (sel_off == OFF_STATUS)   & pwstrb[0] & pwdata[0];

    assign tick   = en & (presc_cnt == prescale);
    assign expire = tick & (count == '0);

    // Read mux, sampled in the setup phase; unmapped offsets read as zero
    always_comb begin
        rd_data = '0;
        case (cur_off)
            OFF_CTRL:     rd_data = {29'd0, ie, auto_rl, en};
            OFF_PRESCALE: rd_data = {16'd0, prescale};
            OFF_LOAD:     rd_data = load;
            OFF_COUNT:    rd_data = count;
            OFF_STATUS:   rd_data = {31'd0, pend};
            default:      rd_data = '0;
        endcase
    end

    // APB handshake: decode and read data captured at setup, pready for one access cycle
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            sel_off <= 3'd0;
        end else begin
            pready  <= setup;
            pslverr <= setup & (cur_off > OFF_STATUS);
            if (setup) sel_off <= cur_off;
            if (setup & ~pwrite) prdata <= rd_data;
        end
    end

    // CTRL: a software write overrides the one-shot hardware EN clear
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            en      <= 1'b0;
            auto_rl <= 1'b0;
            ie      <= 1'b0;
        end else if (wr_ctrl) begin
            en      <= pwdata[0];
            auto_rl <= pwdata[1];
            ie      <= pwdata[2];
        end else if (expire & ~auto_rl) begin
            en      <= 1'b0;
        end
    end

    // PRESCALE register with byte lanes 0 and 1
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            prescale <= 16'd0;
        end else if (wr_prescale) begin
            prescale[15:8] <= pwstrb[1] ? pwdata[15:8] : prescale[15:8];
            prescale[7:0]  <= pwstrb[0] ? pwdata[7:0]  : prescale[7:0];
        end
    end

    // Prescaler counts 0..PRESCALE while enabled; held at 0 when disabled or reprogrammed
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            presc_cnt <= 16'd0;
        end else if (wr_prescale || !en || tick) begin
            presc_cnt <= 16'd0;
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end

    // LOAD register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            load <= RST_LOAD;
        end else if (wr_load) begin
            load <= merge(load, pwdata, pwstrb);
        end
    end

    // COUNT: software write beats a coincident tick; expiry reloads only in AUTO mode
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            count <= '0;
        end else if (wr_count) begin
            count <= merge(count, pwdata, pwstrb);
        end else if (tick) begin
            if (count != '0)  count <= count - 1'b1;
            else if (auto_rl) count <= load;
        end
    end

    // Pending flag: expiry set has priority over the W1C clear
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pend <= 1'b0;
        end else if (expire) begin
            pend <= 1'b1;
        end else if (wr_status) begin
            pend <= 1'b0;
        end
    end

    // Registered level interrupt
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) timer_irq <= 1'b0;
        else          timer_irq <= pend & ie;
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_timer
// Description : Self-checking bench for apb_timer; expected read results are
//               queued as stimulus is issued and popped as transfers complete.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_timer;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [29:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pwstrb = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        timer_irq;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    apb_timer #(.ADDR_W(30), .DATA_W(32), .RST_LOAD(32'hFFFF_FFFF)) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .timer_irq(timer_irq)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // One complete two-cycle APB transfer
    task automatic apb_xfer(input logic [2:0] off, input logic wr, input logic [31:0] wd,
                            input logic [3:0] strb, output logic [31:0] rd,
                            output logic err, output logic rdy, output logic rdy_after);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = {25'd0, off, 2'b00}; pwdata = wd; pwstrb = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        rd = prdata; err = pslverr; rdy = pready;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rdy_after = pready;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] wd);
        logic [31:0] d; logic e, r, ra;
        apb_xfer(off, 1'b1, wd, 4'hF, d, e, r, ra);
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] d, output logic e);
        logic r, ra;
        apb_xfer(off, 1'b0, 32'd0, 4'h0, d, e, r, ra);
    endtask

    task automatic test_reset();
        logic [2:0] offs [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
        logic [31:0] d; logic e, r, ra; exp_t x;
        #1;
        total++; if ({prdata, pready, pslverr, timer_irq} !== 35'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", {prdata, pready, pslverr, timer_irq}); end
        repeat (3) @(posedge pclk);
        #3 presetn = 1'b1;
        exp_q.push_back('{32'd0, 1'b0});
        exp_q.push_back('{32'd0, 1'b0});
        exp_q.push_back('{32'hFFFF_FFFF, 1'b0});
        exp_q.push_back('{32'd0, 1'b0});
        exp_q.push_back('{32'd0, 1'b0});
        exp_q.push_back('{32'd0, 1'b1});
        for (int i = 0; i < 6; i++) begin
            apb_xfer(offs[i], 1'b0, 32'd0, 4'h0, d, e, r, ra);
            x = exp_q.pop_front();
            total++; if (d !== x.data) begin bad++; $display("FAIL reset_read_data off=%0d: got %h want %h", offs[i], d, x.data); end
            total++; if (e !== x.err) begin bad++; $display("FAIL reset_read_err off=%0d: got %b want %b", offs[i], e, x.err); end
            total++; if (r !== 1'b1) begin bad++; $display("FAIL reset_pready off=%0d: got %b want 1", offs[i], r); end
            total++; if (ra !== 1'b0) begin bad++; $display("FAIL reset_pready_drop off=%0d: got %b want 0", offs[i], ra); end
        end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] d; logic e, r, ra; exp_t x;
        apb_xfer(3'd2, 1'b1, 32'h0000_AB00, 4'b0010, d, e, r, ra);
        total++; if (e !== 1'b0 || r !== 1'b1) begin bad++; $display("FAIL strobe_write_resp: got err=%b rdy=%b want err=0 rdy=1", e, r); end
        exp_q.push_back('{32'hFFFF_ABFF, 1'b0});
        rd(3'd2, d, e); x = exp_q.pop_front();
        total++; if (d !== x.data) begin bad++; $display("FAIL strobe_load: got %h want %h", d, x.data); end
        apb_xfer(3'd2, 1'b1, 32'h0, 4'b0000, d, e, r, ra);
        total++; if (e !== 1'b0 || r !== 1'b1) begin bad++; $display("FAIL nostrobe_resp: got err=%b rdy=%b want err=0 rdy=1", e, r); end
        exp_q.push_back('{32'hFFFF_ABFF, 1'b0});
        rd(3'd2, d, e); x = exp_q.pop_front();
        total++; if (d !== x.data) begin bad++; $display("FAIL nostrobe_load: got %h want %h", d, x.data); end
        apb_xfer(3'd5, 1'b1, 32'hFFFF_FFFF, 4'hF, d, e, r, ra);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL unmapped_write_err: got %b want 1", e); end
        exp_q.push_back('{32'd0, 1'b0});
        rd(3'd0, d, e); x = exp_q.pop_front();
        total++; if (d !== x.data) begin bad++; $display("FAIL unmapped_write_effect: got %h want %h", d, x.data); end
    endtask

    task automatic test_periodic();
        int unsigned c0;
        wr(3'd1, 32'd3); wr(3'd3, 32'd2); wr(3'd2, 32'd2); wr(3'd0, 32'h7);
        c0 = cyc;
        while (timer_irq !== 1'b1 && (cyc - c0) < 60) begin @(posedge pclk); #1; end
        total++; if ((cyc - c0) != 13) begin bad++; $display("FAIL periodic_first_irq: got cycle %0d want 13", cyc - c0); end
        wr(3'd4, 32'd1);
        total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL periodic_irq_lag: got %b want 1", timer_irq); end
        @(posedge pclk); #1;
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL periodic_irq_clear: got %b want 0", timer_irq); end
        while (timer_irq !== 1'b1 && (cyc - c0) < 80) begin @(posedge pclk); #1; end
        total++; if ((cyc - c0) != 25) begin bad++; $display("FAIL periodic_second_irq: got cycle %0d want 25", cyc - c0); end
    endtask

    task automatic test_oneshot();
        int unsigned c0; int ones; logic [31:0] d; logic e; exp_t x;
        wr(3'd0, 32'h0); wr(3'd4, 32'h1); wr(3'd1, 32'd0); wr(3'd3, 32'd5); wr(3'd0, 32'h5);
        c0 = cyc;
        while (timer_irq !== 1'b1 && (cyc - c0) < 40) begin @(posedge pclk); #1; end
        total++; if ((cyc - c0) != 7) begin bad++; $display("FAIL oneshot_irq: got cycle %0d want 7", cyc - c0); end
        exp_q.push_back('{32'h4, 1'b0});
        exp_q.push_back('{32'h0, 1'b0});
        rd(3'd0, d, e); x = exp_q.pop_front();
        total++; if (d !== x.data) begin bad++; $display("FAIL oneshot_ctrl: got %h want %h", d, x.data); end
        rd(3'd3, d, e); x = exp_q.pop_front();
        total++; if (d !== x.data) begin bad++; $display("FAIL oneshot_count: got %h want %h", d, x.data); end
        wr(3'd4, 32'h1);
        ones = 0;
        repeat (20) begin @(posedge pclk); #1; if (timer_irq !== 1'b0) ones++; end
        total++; if (ones != 0) begin bad++; $display("FAIL oneshot_no_reexpiry: got %0d irq cycles want 0", ones); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d; logic e; exp_t x;
        wr(3'd0, 32'h0); wr(3'd2, 32'h0); wr(3'd3, 32'h0); wr(3'd1, 32'h0); wr(3'd0, 32'h7);
        repeat (3) @(posedge pclk);
        wr(3'd4, 32'h1);
        exp_q.push_back('{32'h1, 1'b0});
        rd(3'd4, d, e); x = exp_q.pop_front();
        total++; if (d !== x.data) begin bad++; $display("FAIL w1c_collide_pend: got %h want %h", d, x.data); end
        total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL w1c_collide_irq: got %b want 1", timer_irq); end
        wr(3'd0, 32'h6);
        repeat (2) @(posedge pclk);
        wr(3'd4, 32'h1);
        total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_lag: got %b want 1", timer_irq); end
        @(posedge pclk); #1;
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_drop: got %b want 0", timer_irq); end
        exp_q.push_back('{32'h0, 1'b0});
        rd(3'd4, d, e); x = exp_q.pop_front();
        total++; if (d !== x.data) begin bad++; $display("FAIL w1c_pend_cleared: got %h want %h", d, x.data); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d; logic e; exp_t x;
        wr(3'd2, 32'h0); wr(3'd1, 32'h0); wr(3'd3, 32'h0); wr(3'd0, 32'h7);
        repeat (2) @(posedge pclk); #1;
        total++; if (timer_irq !== 1'b1) begin bad++; $display("FAIL areset_pre_irq: got %b want 1", timer_irq); end
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        @(posedge pclk); #1;
        penable = 1'b1;
        total++; if (pready !== 1'b1 || prdata !== 32'h7) begin bad++; $display("FAIL areset_pre_access: got rdy=%b data=%h want rdy=1 data=7", pready, prdata); end
        #2 presetn = 1'b0;
        #1;
        total++; if ({prdata, pready, pslverr, timer_irq} !== 35'd0) begin bad++; $display("FAIL areset_outputs: got %h want 0", {prdata, pready, pslverr, timer_irq}); end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #3 presetn = 1'b1;
        exp_q.push_back('{32'd0, 1'b0});
        exp_q.push_back('{32'd0, 1'b0});
        exp_q.push_back('{32'hFFFF_FFFF, 1'b0});
        exp_q.push_back('{32'd0, 1'b0});
        exp_q.push_back('{32'd0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            rd(3'(i), d, e); x = exp_q.pop_front();
            total++; if (d !== x.data || e !== x.err) begin bad++; $display("FAIL areset_read off=%0d: got %h/%b want %h/%b", i, d, e, x.data, x.err); end
        end
    endtask

    initial begin
        test_reset();
        test_byte_strobe();
        test_periodic();
        test_oneshot();
        test_w1c_collision();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_timer.md
Name: apb_timer

Overview:
- APB3 slave timer on a spare output port of the peripheral APB demultiplexer, in the APB peripheral clock domain on the far side of the async APB FIFO.
- 32-bit down-counter with 16-bit prescaler, reload, one-shot or periodic mode, and a level interrupt.
- The interrupt is routed to a free GPIO interrupt input (gpio_input[5]) next to the UART and SPI interrupts.

Parameters:
- ADDR_W, 30, APB address width seen at the demux output port.
- DATA_W, 32, APB data width; fixed at 32, other values unsupported.
- RST_LOAD, 32'hFFFF_FFFF, reset value of the LOAD register.

Ports:
- pclk  input  1  APB peripheral clock; the only clock.
- presetn  input  1  asynchronous active-low reset.
- paddr  input  ADDR_W  byte address; only paddr[4:2] decoded.
- psel  input  1  APB select.
- penable  input  1  APB access phase.
- pwrite  input  1  1 = write.
- pwdata  input  32  write data.
- pwstrb  input  4  byte write strobes.
- prdata  output  32  read data, valid when pready=1.
- pready  output  1  transfer complete.
- pslverr  output  1  error response, valid when pready=1.
- timer_irq  output  1  level interrupt.

Behaviour:
- Clock and reset: one clock, pclk. presetn is asynchronous and active-low. All flops reset asynchronously on presetn=0.
- Reset values: prdata=0, pready=0, pslverr=0, timer_irq=0, CTRL=0, PRESCALE=0, LOAD=RST_LOAD, COUNT=0, pending=0, prescaler counter=0.
- Register map (paddr[4:2]):
  - 0 = CTRL: [0] EN, [1] AUTO (periodic), [2] IE.
  - 1 = PRESCALE: [15:0]; tick every PRESCALE+1 pclk cycles.
  - 2 = LOAD: [31:0].
  - 3 = COUNT: [31:0], read/write.
  - 4 = STATUS: [0] PEND; write 1 to clear.
  - 5..7 unmapped.
- Reserved bits read 0 and ignore writes.
- APB timing:
  - Setup phase (psel=1, penable=0): register the decode and read data.
  - Access phase (psel=1, penable=1): pready=1 for exactly one cycle, so every transfer is 2 cycles with no extra wait states.
  - Writes commit on the access-phase edge.
  - pready and pslverr return to 0 in the cycle after the access phase.
  - prdata holds its last value outside the access phase.
- Unmapped offset: pslverr=1 with pready; a write has no effect and a read returns 0.
- Byte strobes: pwstrb[i] gates pwdata[8i+7:8i]. A write with pwstrb=0 is a no-op but completes with pslverr=0.
- Prescaler:
  - While EN=1, the prescaler counts 0..PRESCALE and a tick is generated on the cycle it equals PRESCALE, then it wraps to 0.
  - While EN=0 the prescaler is held at 0.
  - Any write to PRESCALE clears the prescaler.
- Counter, on each tick:
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0: PEND <= 1. If AUTO=1, COUNT <= LOAD. If AUTO=0, COUNT stays 0 and EN <= 0 (hardware clear, visible in CTRL).
- Interrupt: timer_irq is registered, equal to PEND & IE, and appears one cycle after PEND changes.
- Simultaneous events:
  - APB write to COUNT in the same cycle as a tick: the write wins and no decrement is applied.
  - STATUS W1C in the same cycle as an expiry: the set wins, so PEND stays 1.
  - CTRL write in the same cycle as a one-shot hardware EN clear: the written value wins.
- Disable mid-count: COUNT holds its value. Re-enabling resumes from the held value with a fresh prescaler.
- Wrap: LOAD=0 with AUTO=1 expires on every tick.
- Reset mid-transfer: the transfer is aborted and pready is forced to 0 immediately (asynchronously).

Test Plan:
- Reset, then read all offsets 0..4 -> 0, 0, 0xFFFF_FFFF, 0, 0. Each read has pready high for 1 cycle and pslverr=0. Read offset 6 -> prdata=0, pslverr=1.
- PRESCALE=3, COUNT=2, LOAD=2, CTRL=0x7 -> first PEND=1 exactly 12 pclk after the CTRL write commits. timer_irq rises 1 cycle later. COUNT reloads to 2 and re-expires every 12 cycles.
- One-shot (CTRL=0x5, PRESCALE=0, COUNT=5) -> PEND after 6 cycles, CTRL reads 0x4, COUNT stays 0, no further expiry.
- Write STATUS=1 timed to coincide with a periodic expiry (PRESCALE=0, LOAD=0) -> PEND remains 1. A W1C on a non-expiry cycle drops timer_irq one cycle later.
- Byte write to LOAD with pwstrb=4'b0010 and pwdata=0x0000_AB00, from 0xFFFF_FFFF -> LOAD reads 0xFFFF_ABFF.
- Assert presetn low mid-count and during an access phase -> all outputs are 0 immediately, and registers read their reset values after release.
